bcd_display_ctrl: RTL



---
 rtl/bcd_display_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_display_ctrl.sv
// Sequential binary-to-BCD converter driving one active-low seven-segment
// display per decimal digit. A double-dabble (shift/add-3) engine processes
// one input bit per clock under a start/busy/done handshake. The result is
// held in a register, and the segment patterns are decoded from that
// register, with optional leading-zero blanking.
module bcd_display_ctrl #(
   parameter int W      = 8,
   parameter int DIGITS = 3,
   parameter bit BLANK  = 1'b1
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic                  start,
   input  logic [W-1:0]          bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   HEX
);

   // Width of the bit counter: it must be able to hold the value W.
   localparam int CNT_W = (W < 2) ? 1 : $clog2(W + 1);

   // 10^n, used to check at elaboration that DIGITS can hold the largest input.
   function automatic longint pow10(input int n);
      longint r;
      r = longint'(1);
      for (int k = 0; k < n; k++) begin
         r = r * longint'(10);
      end
      return r;
   endfunction

   localparam longint MAX_BIN = (longint'(1) << W) - longint'(1);

   if (W < 1 || W > 16) begin : g_bad_width
      $error("bcd_display_ctrl: W must lie in 1..16");
   end
   if (DIGITS < 1 || pow10(DIGITS) <= MAX_BIN) begin : g_bad_digits
      $error("bcd_display_ctrl: DIGITS too small to represent 2^W-1");
   end

   // Active-low seven-segment pattern {g,f,e,d,c,b,a} for one BCD digit.
   // Codes 10..15 cannot arise from a valid conversion; they are shown blank.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h18;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_LOAD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [W-1:0]              shift_q, shift_d;
   logic [4*DIGITS-1:0]       acc_q,   acc_d;
   logic [CNT_W-1:0]          cnt_q,   cnt_d;
   logic [4*DIGITS-1:0]       bcd_q,   bcd_d;
   logic                      busy_q,  busy_d;
   logic                      done_q,  done_d;

   logic [4*DIGITS-1:0]       adj_s;
   logic [4*DIGITS+W-1:0]     shifted_s;
   logic [7*DIGITS-1:0]       hex_s;
   logic                      upper_zero_s;

   // Digit correction: any accumulator digit of 5 or more gets 3 added, so
   // the following left shift carries correctly into the next decimal digit.
   // The addition is 4-bit and never carries into the neighbouring digit.
   always_comb begin
      adj_s = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            adj_s[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end else begin
            adj_s[4*i +: 4] = acc_q[4*i +: 4];
         end
      end
      shifted_s = {adj_s, shift_q} << 1'b1;
   end

   // Next-state logic for the handshake and conversion sequence.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               shift_d = bin;
               acc_d   = {(4*DIGITS){1'b0}};
               cnt_d   = CNT_W'(W);
               busy_d  = 1'b1;
               state_d = S_CONV;
            end else begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_CONV: begin
            acc_d   = shifted_s[W +: 4*DIGITS];
            shift_d = shifted_s[W-1:0];
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_CONV;
            end
         end
         S_LOAD: begin
            bcd_d   = acc_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset abandons any conversion in flight.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_IDLE;
         shift_q <= {W{1'b0}};
         acc_q   <= {(4*DIGITS){1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         bcd_q   <= {(4*DIGITS){1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Segment decode from the registered result. Scanning from the most
   // significant digit down, a digit is blanked while it and every digit
   // above it are zero. The ones digit is always shown.
   always_comb begin
      hex_s        = {(7*DIGITS){1'b1}};
      upper_zero_s = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         upper_zero_s = upper_zero_s & (bcd_q[4*i +: 4] == 4'd0);
         if (BLANK && (i > 0) && upper_zero_s) begin
            hex_s[7*i +: 7] = 7'h7F;
         end else begin
            hex_s[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;
   assign HEX  = hex_s;

endmodule
